// File: rtl/key_pulse_gen.sv
// ---------------------------------------------------------------------------
// key_pulse_gen
//
// Turns raw mechanical push-button pads into clean command pulses for the
// delay-control stage. Each key channel runs on its own, with no priority
// between keys:
//   raw pad -> two-flop synchroniser -> counter debounce FSM -> press edge
// One accepted press produces exactly one single-cycle key_pulse. With
// AUTO_REPEAT_EN it also produces timed repeat pulses while the key is held.
//
// Optional feature macro: AUTO_REPEAT_EN
//   undefined (default): exactly one pulse per press. REPEAT_* are ignored.
//   defined            : a key held in HELD repeats. The first repeat comes
//                        REPEAT_DELAY cycles after the press pulse, and later
//                        repeats come every REPEAT_PERIOD cycles.
//
// Parameters
//   NUM_KEYS        number of independent key channels
//   DEBOUNCE_CYCLES stable synchronised cycles to accept a press/release
//   CNT_W           width of each per-key counter
//   KEY_ACTIVE_LOW  1: raw 0 means pressed, 0: raw 1 means pressed
//   REPEAT_DELAY    press pulse to first repeat pulse (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD   spacing of later repeat pulses (AUTO_REPEAT_EN only)
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   key_raw    raw asynchronous key pads, NUM_KEYS wide
//   key_pulse  registered one-cycle active-high pulse per accepted press/repeat
//   key_level  registered debounced active-high pressed level
// ---------------------------------------------------------------------------
module key_pulse_gen #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_e;

  // Raw pad level that means "not pressed"; also the synchroniser reset value.
  localparam logic RELEASED_LVL = (KEY_ACTIVE_LOW != 0);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Terminal counts. The compare happens before the increment, so a counter
  // never needs to hold a value above its terminal count and cannot wrap.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Elaboration-time parameter legality checks.
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
    $error("key_pulse_gen: DEBOUNCE_CYCLES must be in 1..2**CNT_W-1");
  end

`ifdef AUTO_REPEAT_EN
  // A repeat interval of 1 would put pulses on back-to-back cycles.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
      longint'(REPEAT_DELAY) > CNT_MAX || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_repeat
    $error("key_pulse_gen: REPEAT_DELAY/REPEAT_PERIOD must be in 2..2**CNT_W-1");
  end
`else
  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat
    $error("key_pulse_gen: REPEAT_DELAY/REPEAT_PERIOD must not be negative");
  end
`endif

  // -------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchroniser. It resets to the released level so
  // that a reset never looks like a press.
  // -------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;
  logic [NUM_KEYS-1:0] pressed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= {NUM_KEYS{RELEASED_LVL}};
      sync_p1 <= {NUM_KEYS{RELEASED_LVL}};
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = sync_p1 ^ {NUM_KEYS{RELEASED_LVL}};

  // -------------------------------------------------------------------------
  // Stage p2: per-channel debounce FSM with registered pulse/level outputs
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             level_q;
    logic             level_d;
`ifdef AUTO_REPEAT_EN
    // Set once the first (REPEAT_DELAY) repeat of the current hold has fired,
    // so that later repeats use REPEAT_PERIOD.
    logic             rep_q;
    logic             rep_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
`ifdef AUTO_REPEAT_EN
        rep_q   <= rep_d;
`endif
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d   = rep_q;
`endif

      case (state_q)
        IDLE: begin
          if (pressed[k]) begin
            state_d = DEB_PRESS;
            cnt_d   = '0;
          end
        end

        DEB_PRESS: begin
          if (!pressed[k]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        HELD: begin
          if (!pressed[k]) begin
            state_d = DEB_RELEASE;
            cnt_d   = '0;
          end
`ifdef AUTO_REPEAT_EN
          // The counter starts from 0 on the press pulse. The first repeat
          // therefore fires exactly REPEAT_DELAY cycles later and cannot
          // coincide with the press pulse.
          else if (cnt_q == (rep_q ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
            rep_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end

        DEB_RELEASE: begin
          if (pressed[k]) begin
            // A release bounce returns to HELD silently. The level never
            // dropped, so this is not a new press.
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // The level follows the next state, so it rises on the same edge as
      // the press pulse and falls on the edge that accepts the release.
      level_d = (state_d == HELD) || (state_d == DEB_RELEASE);
    end

    assign key_pulse[k] = pulse_q;
    assign key_level[k] = level_q;
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_key_pulse_gen
//
// Directed bench for key_pulse_gen.
// The main instance uses DEBOUNCE_CYCLES=4 with active-low keys, so a press
// pulse lands on edge 7 after the raw change. A second instance uses
// DEBOUNCE_CYCLES=1 with active-high keys, so its pulse lands on edge 4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled there
// too, which reflects the state loaded by that edge. "Edge c" is the c-th
// rising edge after the stimulus change.
// ---------------------------------------------------------------------------
module tb_key_pulse_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_raw;
  logic [1:0] key_pulse;
  logic [1:0] key_level;
  logic [0:0] key_raw1;
  logic [0:0] key_pulse1;
  logic [0:0] key_level1;

  int n_tests = 0;
  int n_fail  = 0;

  // Independent pulse bookkeeping, sampled mid-cycle on the falling edge.
  int         pulse_cnt0 = 0;
  int         pulse_cnt1 = 0;
  int         consec     = 0;
  logic [1:0] prev_pulse = 2'b00;
  logic [0:0] prev_pulse1 = 1'b0;

  always #5 clk = ~clk;

  key_pulse_gen #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8),
    .KEY_ACTIVE_LOW (1),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_raw  (key_raw),
    .key_pulse(key_pulse),
    .key_level(key_level)
  );

  key_pulse_gen #(
    .NUM_KEYS       (1),
    .DEBOUNCE_CYCLES(1),
    .CNT_W          (8),
    .KEY_ACTIVE_LOW (0),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut_d1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_raw  (key_raw1),
    .key_pulse(key_pulse1),
    .key_level(key_level1)
  );

  always @(negedge clk) begin
    if (key_pulse[0]) pulse_cnt0++;
    if (key_pulse[1]) pulse_cnt1++;
    if ((key_pulse & prev_pulse) != 2'b00) consec++;
    if ((key_pulse1 & prev_pulse1) != 1'b0) consec++;
    prev_pulse  = key_pulse;
    prev_pulse1 = key_pulse1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         base;
  logic [1:0] exp_p;
  logic [1:0] exp_l;

  initial begin
    reset_n  = 1'b0;
    key_raw  = 2'b11;
    key_raw1 = 1'b0;
    step(2);
    check("reset_pulse", 32'(key_pulse), 32'h0);
    check("reset_level", 32'(key_level), 32'h0);
    check("reset_pulse_d1", 32'(key_pulse1), 32'h0);
    reset_n = 1'b1;
    step(3);
    check("idle_pulse", 32'(key_pulse), 32'h0);
    check("idle_level", 32'(key_level), 32'h0);

    // Clean press on key 1: pulse on edge 7 only, level from edge 7.
    base    = pulse_cnt1;
    key_raw = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      check($sformatf("press_pulse c=%0d", c), 32'(key_pulse), (c == 7) ? 32'h2 : 32'h0);
      check($sformatf("press_level c=%0d", c), 32'(key_level), (c >= 7) ? 32'h2 : 32'h0);
    end
    key_raw = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check($sformatf("release_level c=%0d", c), 32'(key_level), (c < 7) ? 32'h2 : 32'h0);
      check($sformatf("release_pulse c=%0d", c), 32'(key_pulse), 32'h0);
    end
    check("press_count", 32'(pulse_cnt1 - base), 32'd1);

    // Bounce on key 0: low 3, high 1, low 2, then high. Nothing may come out.
    base = pulse_cnt0;
    for (int c = 1; c <= 16; c++) begin
      key_raw[0] = (c <= 3 || c == 5 || c == 6) ? 1'b0 : 1'b1;
      step(1);
      check($sformatf("bounce_pulse c=%0d", c), 32'(key_pulse), 32'h0);
      check($sformatf("bounce_level c=%0d", c), 32'(key_level), 32'h0);
    end
    check("bounce_count", 32'(pulse_cnt0 - base), 32'd0);

    // Simultaneous press of both keys.
    key_raw = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check($sformatf("simul_pulse c=%0d", c), 32'(key_pulse), (c == 7) ? 32'h3 : 32'h0);
      check($sformatf("simul_level c=%0d", c), 32'(key_level), (c >= 7) ? 32'h3 : 32'h0);
    end
    key_raw = 2'b11;
    step(10);
    check("simul_release_level", 32'(key_level), 32'h0);

    // Release bounce on key 1: high for 2 cycles, then low again.
    base    = pulse_cnt1;
    key_raw = 2'b01;
    step(10);
    check("relb_level_held", 32'(key_level), 32'h2);
    key_raw = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) key_raw = 2'b01;
      step(1);
      check($sformatf("relb_level c=%0d", c), 32'(key_level), 32'h2);
      check($sformatf("relb_pulse c=%0d", c), 32'(key_pulse), 32'h0);
    end
    key_raw = 2'b11;
    step(10);
    check("relb_final_level", 32'(key_level), 32'h0);
    check("relb_count", 32'(pulse_cnt1 - base), 32'd1);

    // Reset during DEB_PRESS, then during HELD, with key 0 held throughout.
    key_raw = 2'b10;
    step(4);
    reset_n = 1'b0;
    #1;
    check("rst_deb_pulse", 32'(key_pulse), 32'h0);
    check("rst_deb_level", 32'(key_level), 32'h0);
    step(1);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check($sformatf("rst1_pulse c=%0d", c), 32'(key_pulse), (c == 7) ? 32'h1 : 32'h0);
    end
    check("rst1_level", 32'(key_level), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_held_level_async", 32'(key_level), 32'h0);
    check("rst_held_pulse_async", 32'(key_pulse), 32'h0);
    step(2);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check($sformatf("rst2_pulse c=%0d", c), 32'(key_pulse), (c == 7) ? 32'h1 : 32'h0);
      check($sformatf("rst2_level c=%0d", c), 32'(key_level), (c >= 7) ? 32'h1 : 32'h0);
    end
    key_raw = 2'b11;
    step(10);
    check("rst_final_level", 32'(key_level), 32'h0);

    // DEBOUNCE_CYCLES=1 with active-high polarity: accept on edge 4.
    key_raw1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check($sformatf("d1_pulse c=%0d", c), 32'(key_pulse1), (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("d1_level c=%0d", c), 32'(key_level1), (c >= 4) ? 32'h1 : 32'h0);
    end
    key_raw1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      check($sformatf("d1_rel_level c=%0d", c), 32'(key_level1), (c < 4) ? 32'h1 : 32'h0);
    end

    // Long hold of key 1 for 30 cycles. Without auto-repeat only the press
    // pulse appears. With it, repeats appear 10 cycles later, then every 3
    // cycles, until the release reaches the FSM on edge 33.
    base    = pulse_cnt1;
    key_raw = 2'b01;
    for (int c = 1; c <= 42; c++) begin
      if (c == 31) key_raw = 2'b11;
      step(1);
`ifdef AUTO_REPEAT_EN
      exp_p = (c == 7 || c == 17 || c == 20 || c == 23 ||
               c == 26 || c == 29 || c == 32) ? 2'b10 : 2'b00;
`else
      exp_p = (c == 7) ? 2'b10 : 2'b00;
`endif
      exp_l = (c >= 7 && c < 37) ? 2'b10 : 2'b00;
      check($sformatf("hold_pulse c=%0d", c), 32'(key_pulse), 32'(exp_p));
      check($sformatf("hold_level c=%0d", c), 32'(key_level), 32'(exp_l));
    end
`ifdef AUTO_REPEAT_EN
    check("hold_count", 32'(pulse_cnt1 - base), 32'd7);
`else
    check("hold_count", 32'(pulse_cnt1 - base), 32'd1);
`endif

    check("no_consecutive_pulses", 32'(consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
